// File: rtl/veopixel_frame_controller.sv
// ---------------------------------------------------------------------------
// veopixel_frame_controller
//
// Streams one LED-strip frame for the VeoPixels output path.
// After a start request it reads NUM_LEDS 24-bit pixels from an external
// pixel memory. For every bit it emits one 2-bit symbol, MSB first, for
// BIT_CYCLES clocks. It then holds the latch symbol for RESET_CYCLES clocks
// and pulses done. The next LED's pixel is prefetched during the bit-0 slot
// of the current LED, so LEDs follow each other with no gap.
//
// Optional feature macro: VEO_BRIGHTNESS_EN
//   defined   -> each 8-bit channel is scaled by (brightness+1)/256 at capture,
//                with brightness sampled when the frame is accepted
//   undefined -> pix_data is passed through unchanged; brightness is ignored
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   synchronous active-low reset
//   start       in   frame request, only honoured in IDLE
//   brightness  in   8-bit global scale (VEO_BRIGHTNESS_EN only)
//   busy        out  high from the cycle after accept through the done cycle
//   done        out  one-cycle pulse at frame end
//   pix_rd      out  one-cycle pixel read strobe
//   pix_addr    out  pixel index 0..NUM_LEDS-1
//   pix_data    in   pixel word, valid one cycle after pix_rd
//   sym_strobe  out  pulse on the first clock of every slot and of the latch
//   symbol      out  00 = bit 0, 01 = bit 1, 11 = reset/latch
// ---------------------------------------------------------------------------
module veopixel_frame_controller #(
  parameter int NUM_LEDS     = 8,
  parameter int BIT_CYCLES   = 61,
  parameter int RESET_CYCLES = 2500,
  parameter int AW           = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [7:0]    brightness,
  output logic          busy,
  output logic          done,
  output logic          pix_rd,
  output logic [AW-1:0] pix_addr,
  input  logic [23:0]   pix_data,
  output logic          sym_strobe,
  output logic [1:0]    symbol
);

  localparam int SW = $clog2(BIT_CYCLES);
  localparam int LW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  localparam logic [SW-1:0] SLOT_LAST  = SW'(BIT_CYCLES - 1);
  localparam logic [LW-1:0] LATCH_LAST = LW'(RESET_CYCLES - 1);
  localparam logic [AW-1:0] LED_LAST   = AW'(NUM_LEDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_SHIFT,
    S_LATCH,
    S_DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [SW-1:0] slot_cnt;
  logic [4:0]    bit_cnt;
  logic [AW-1:0] led_idx;
  logic [LW-1:0] latch_cnt;
  logic [23:0]   shreg;
  logic [23:0]   hold;
  logic          hold_pending;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] rd_addr;
  logic [23:0]   pix_word;

  logic slot_first;
  logic slot_end;
  logic last_bit;
  logic last_led;
  logic prefetch;
  logic accept;

  assign slot_first = (slot_cnt == '0);
  assign slot_end   = (slot_cnt == SLOT_LAST);
  assign last_bit   = (bit_cnt == 5'd0);
  assign last_led   = (led_idx == LED_LAST);
  assign accept     = (state == S_IDLE) && start;

  // The next pixel is requested on the first clock of the bit-0 slot so that
  // it is sitting in the holding register well before the slot ends.
  assign prefetch = (state == S_SHIFT) && slot_first && last_bit && !last_led;

  // pix_addr holds the last read address between strobes, so it never
  // jumps around while no read is in flight.
  assign pix_addr = pix_rd ? rd_addr : addr_q;

`ifdef VEO_BRIGHTNESS_EN
  // Brightness scaling: three independent 8x9 products, high byte kept.
  logic [7:0]  bright_q;
  logic [8:0]  scale;
  logic [15:0] prod_r;
  logic [15:0] prod_g;
  logic [15:0] prod_b;
  logic        unused_prod;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bright_q <= 8'd0;
    end else if (accept) begin
      bright_q <= brightness;
    end
  end

  assign scale       = {1'b0, bright_q} + 9'd1;
  assign prod_r      = {8'd0, pix_data[23:16]} * {7'd0, scale};
  assign prod_g      = {8'd0, pix_data[15:8]}  * {7'd0, scale};
  assign prod_b      = {8'd0, pix_data[7:0]}   * {7'd0, scale};
  assign pix_word    = {prod_r[15:8], prod_g[15:8], prod_b[15:8]};
  assign unused_prod = ^{prod_r[7:0], prod_g[7:0], prod_b[7:0]};
`else
  logic unused_brightness;

  assign pix_word          = pix_data;
  assign unused_brightness = ^brightness;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    pix_rd     = 1'b0;
    rd_addr    = '0;
    sym_strobe = 1'b0;
    symbol     = 2'b11;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_FETCH;
        end
      end

      S_FETCH: begin
        busy       = 1'b1;
        pix_rd     = 1'b1;
        rd_addr    = '0;
        state_next = S_LOAD;
      end

      S_LOAD: begin
        busy       = 1'b1;
        state_next = S_SHIFT;
      end

      S_SHIFT: begin
        busy       = 1'b1;
        symbol     = {1'b0, shreg[23]};
        sym_strobe = slot_first;
        if (prefetch) begin
          pix_rd  = 1'b1;
          rd_addr = led_idx + AW'(1);
        end
        if (slot_end && last_bit && last_led) begin
          state_next = S_LATCH;
        end
      end

      S_LATCH: begin
        busy       = 1'b1;
        sym_strobe = (latch_cnt == '0);
        if (latch_cnt == LATCH_LAST) begin
          state_next = S_DONE;
        end
      end

      S_DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Datapath: slot/bit/LED/latch counters, shift register and prefetch
  // holding register. Counters are re-armed on accept so an aborted frame
  // leaves nothing behind for the next one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_cnt     <= '0;
      bit_cnt      <= 5'd0;
      led_idx      <= '0;
      latch_cnt    <= '0;
      shreg        <= 24'd0;
      hold         <= 24'd0;
      hold_pending <= 1'b0;
      addr_q       <= '0;
    end else begin
      hold_pending <= prefetch;

      if (pix_rd) begin
        addr_q <= rd_addr;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            slot_cnt  <= '0;
            bit_cnt   <= 5'd23;
            led_idx   <= '0;
            latch_cnt <= '0;
          end
        end

        S_LOAD: begin
          shreg <= pix_word;
        end

        S_SHIFT: begin
          if (hold_pending) begin
            hold <= pix_word;
          end
          if (slot_end) begin
            slot_cnt <= '0;
            if (last_bit) begin
              // Next LED starts with its bit 23 right after this slot.
              bit_cnt <= 5'd23;
              shreg   <= hold;
              if (!last_led) begin
                led_idx <= led_idx + AW'(1);
              end
            end else begin
              bit_cnt <= bit_cnt - 5'd1;
              shreg   <= {shreg[22:0], 1'b0};
            end
          end else begin
            slot_cnt <= slot_cnt + SW'(1);
          end
        end

        S_LATCH: begin
          latch_cnt <= latch_cnt + LW'(1);
        end

        S_DONE: begin
          latch_cnt <= '0;
        end

        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_veopixel_frame_controller.sv
// ---------------------------------------------------------------------------
// tb_veopixel_frame_controller
//
// Scoreboard bench for veopixel_frame_controller (NUM_LEDS=2, BIT_CYCLES=4,
// RESET_CYCLES=10). Starting a frame pushes the expected read strobes,
// symbol strobes and done pulse, each tagged with its expected cycle, into
// queues. A monitor on the falling edge pops and compares them as the DUT
// produces them. A small pixel memory answers pix_rd one cycle later and
// drives random data at all other times.
// ---------------------------------------------------------------------------
module tb_veopixel_frame_controller;

  localparam int NL = 2;
  localparam int BC = 4;
  localparam int RC = 10;
  localparam int AW = 1;
  localparam int FRAME = 3 + 24 * NL * BC + RC;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [7:0]    brightness;
  logic          busy;
  logic          done;
  logic          pix_rd;
  logic [AW-1:0] pix_addr;
  logic [23:0]   pix_data = 24'd0;
  logic          sym_strobe;
  logic [1:0]    symbol;

  veopixel_frame_controller #(
    .NUM_LEDS    (NL),
    .BIT_CYCLES  (BC),
    .RESET_CYCLES(RC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .brightness(brightness),
    .busy      (busy),
    .done      (done),
    .pix_rd    (pix_rd),
    .pix_addr  (pix_addr),
    .pix_data  (pix_data),
    .sym_strobe(sym_strobe),
    .symbol    (symbol)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    logic [1:0]  sym;
  } sym_ev_t;

  typedef struct {
    int unsigned cyc;
    int unsigned addr;
  } rd_ev_t;

  sym_ev_t     sym_q[$];
  rd_ev_t      rd_q[$];
  int unsigned done_q[$];

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  int rd_cnt   = 0;
  logic       mon_en  = 1'b0;
  logic [1:0] cur_sym = 2'b11;

  logic [23:0]   mem [NL];
  logic          rd_seen;
  logic [AW-1:0] rd_addr_seen;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Pixel memory: data is valid only in the cycle right after a read strobe.
  always @(negedge clk) begin
    rd_seen      = pix_rd;
    rd_addr_seen = pix_addr;
  end

  always @(posedge clk) begin
    #1;
    if (rd_seen === 1'b1) pix_data = mem[rd_addr_seen];
    else                  pix_data = 24'($urandom);
  end

  // Expected events for a frame accepted at the edge ending cycle acc.
  function automatic void pushExpected(input int unsigned acc, input logic [23:0] e0, input logic [23:0] e1);
    logic [23:0] w [NL];
    sym_ev_t se;
    rd_ev_t  re;
    w[0] = e0;
    w[1] = e1;
    re.cyc = acc + 1; re.addr = 0;
    rd_q.push_back(re);
    for (int led = 0; led < NL; led++) begin
      for (int b = 23; b >= 0; b--) begin
        se.cyc = acc + 3 + (led * 24 + (23 - b)) * BC;
        se.sym = {1'b0, w[led][b]};
        sym_q.push_back(se);
      end
      if (led < NL - 1) begin
        re.cyc  = acc + 3 + (led * 24 + 23) * BC;
        re.addr = led + 1;
        rd_q.push_back(re);
      end
    end
    se.cyc = acc + 3 + 24 * NL * BC;
    se.sym = 2'b11;
    sym_q.push_back(se);
    done_q.push_back(acc + FRAME);
  endfunction

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      while (rd_q.size() > 0 && rd_q[0].cyc < cyc) begin
        checkOutput("rd_missing", cyc, rd_q[0].cyc);
        rd_q.delete(0);
      end
      while (sym_q.size() > 0 && sym_q[0].cyc < cyc) begin
        checkOutput("sym_missing", cyc, sym_q[0].cyc);
        sym_q.delete(0);
      end
      while (done_q.size() > 0 && done_q[0] < cyc) begin
        checkOutput("done_missing", cyc, done_q[0]);
        done_q.delete(0);
      end

      if (pix_rd === 1'b1) begin
        rd_cnt++;
        if (rd_q.size() == 0) checkOutput("rd_extra", rd_q.size(), 1);
        else if (rd_q[0].cyc != cyc) checkOutput("rd_early", cyc, rd_q[0].cyc);
        else begin
          checkOutput("rd_addr", pix_addr, rd_q[0].addr);
          rd_q.delete(0);
        end
      end

      if (sym_strobe === 1'b1) begin
        if (sym_q.size() == 0) checkOutput("sym_extra", sym_q.size(), 1);
        else if (sym_q[0].cyc != cyc) checkOutput("sym_early", cyc, sym_q[0].cyc);
        else begin
          checkOutput("symbol", symbol, sym_q[0].sym);
          checkOutput("busy_in_frame", busy, 1);
          cur_sym = sym_q[0].sym;
          sym_q.delete(0);
        end
      end else if (busy === 1'b1) begin
        checkOutput("sym_hold", symbol, cur_sym);
      end else begin
        checkOutput("idle_sym", symbol, 2'b11);
        cur_sym = 2'b11;
      end

      if (done === 1'b1) begin
        done_cnt++;
        if (done_q.size() == 0) checkOutput("done_extra", done_q.size(), 1);
        else if (done_q[0] != cyc) checkOutput("done_early", cyc, done_q[0]);
        else begin
          checkOutput("busy_at_done", busy, 1);
          done_q.delete(0);
        end
      end
    end
  end

  task automatic waitUntil(input int unsigned c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitDone(input int target);
    int budget = 0;
    while (done_cnt < target && budget < 600) begin
      @(posedge clk);
      #1;
      budget++;
    end
    checkOutput("done_timeout", done_cnt, target);
  endtask

  task automatic applyStimulus(input logic [23:0] m0, input logic [23:0] m1, input logic [7:0] b,
                               input logic [23:0] e0, input logic [23:0] e1, output int unsigned acc);
    @(posedge clk);
    #1;
    mem[0]     = m0;
    mem[1]     = m1;
    brightness = b;
    start      = 1'b1;
    acc        = cyc;
    pushExpected(acc, e0, e1);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic pulseStart(input int unsigned c);
    waitUntil(c);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_symbol"}, symbol, 2'b11);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_pix_rd"}, pix_rd, 0);
    checkOutput({tag, "_strobe"}, sym_strobe, 0);
    checkOutput({tag, "_addr"}, pix_addr, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int unsigned acc;
    int unsigned acc2;
    int unsigned rc;
    int d0;
    int r0;
    logic [23:0] exp_a;
    logic [23:0] exp_b;

    rst_n      = 1'b0;
    start      = 1'b0;
    brightness = 8'hFF;
    mem[0]     = 24'd0;
    mem[1]     = 24'd0;
    repeat (3) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Reset state after a stretch of idle.
    repeat (20) @(posedge clk);
    @(negedge clk);
    checkIdle("reset");

    // Basic frame.
    applyStimulus(24'hA50000, 24'h00003C, 8'hFF, 24'hA50000, 24'h00003C, acc);
    waitDone(1);

    // start pulses during SHIFT and LATCH must be ignored.
    d0 = done_cnt;
    r0 = rd_cnt;
    applyStimulus(24'hA50000, 24'h00003C, 8'hFF, 24'hA50000, 24'h00003C, acc);
    pulseStart(acc + 50);
    pulseStart(acc + 120);
    pulseStart(acc + 3 + 24 * NL * BC + 1);
    pulseStart(acc + 3 + 24 * NL * BC + 7);
    waitDone(d0 + 1);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("ignore_done_count", done_cnt - d0, 1);
    checkOutput("ignore_rd_count", rd_cnt - r0, 2);

    // Reset in the middle of LED 1 bit 10.
    d0 = done_cnt;
    applyStimulus(24'h5AC3F0, 24'h81FF18, 8'hFF, 24'h5AC3F0, 24'h81FF18, acc);
    rc = acc + 3 + (24 + 13) * BC + 1;
    waitUntil(rc);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sym_q.delete();
    rd_q.delete();
    done_q.delete();
    @(negedge clk);
    checkIdle("abort");
    repeat (15) @(posedge clk);
    #1;
    checkOutput("abort_no_done", done_cnt, d0);

    // Full frame after the abort.
    applyStimulus(24'h5AC3F0, 24'h81FF18, 8'hFF, 24'h5AC3F0, 24'h81FF18, acc);
    waitDone(d0 + 1);

    // Brightness scaling (identity when the feature is not built).
`ifdef VEO_BRIGHTNESS_EN
    exp_a = 24'h7F4000;
    exp_b = 24'h091A2B;
`else
    exp_a = 24'hFF8001;
    exp_b = 24'h123456;
`endif
    d0 = done_cnt;
    applyStimulus(24'hFF8001, 24'h123456, 8'd127, exp_a, exp_b, acc);
    waitDone(d0 + 1);
    applyStimulus(24'hFF8001, 24'h123456, 8'd255, 24'hFF8001, 24'h123456, acc);
    waitDone(d0 + 2);

    // start held high: back-to-back frames, one IDLE cycle between them.
    d0 = done_cnt;
    @(posedge clk);
    #1;
    mem[0]     = 24'h0F0F0F;
    mem[1]     = 24'hF0F0F0;
    brightness = 8'hFF;
    start      = 1'b1;
    acc        = cyc;
    pushExpected(acc, 24'h0F0F0F, 24'hF0F0F0);
    acc2 = acc + FRAME + 1;
    pushExpected(acc2, 24'h0F0F0F, 24'hF0F0F0);
    waitUntil(acc2 + 1);
    start = 1'b0;
    waitDone(d0 + 2);

    repeat (20) @(posedge clk);
    #1;
    checkOutput("left_sym", sym_q.size(), 0);
    checkOutput("left_rd", rd_q.size(), 0);
    checkOutput("left_done", done_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/veopixel_frame_controller.md
# veopixel_frame_controller

Sequences a full LED-strip frame for the VeoPixels output path. On `start` it reads `NUM_LEDS` 24-bit pixels from an external pixel memory and emits one 2-bit symbol per bit slot (`BIT_CYCLES` clocks each), MSB first, with no gaps between LEDs. It then holds the reset/latch symbol for `RESET_CYCLES` clocks and pulses `done`. It sits between the frame/pixel store and the bit-level waveform encoder, which consumes `symbol`.

## Interface
- `NUM_LEDS`, default 8: LEDs per frame, ≥1.
- `BIT_CYCLES`, default 61: clocks per bit slot (1220 ns at 50 MHz), ≥4.
- `RESET_CYCLES`, default 2500: clocks of latch symbol after the last bit (50 µs at 50 MHz), ≥1.
- `AW`, default `$clog2(NUM_LEDS)` (min 1): pixel address width.

Ports:
- `clk`  in  1  50 MHz system clock; all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  frame request; sampled only in IDLE.
- `brightness`  in  8  global scale; used only with `VEO_BRIGHTNESS_EN`.
- `busy`  out  1  high from the cycle after `start` is accepted through the `done` cycle.
- `done`  out  1  one-cycle pulse at frame end.
- `pix_rd`  out  1  one-cycle pixel read strobe.
- `pix_addr`  out  AW  pixel index, 0..NUM_LEDS-1.
- `pix_data`  in  24  pixel word; valid exactly one cycle after `pix_rd`.
- `sym_strobe`  out  1  one-cycle pulse on the first clock of every slot and of the latch period.
- `symbol`  out  2  2'b00 = bit 0, 2'b01 = bit 1, 2'b11 = reset/latch; held stable for the whole slot.

## Operation
- States:
  - IDLE → FETCH (on `start`).
  - FETCH → LOAD.
  - LOAD → SHIFT.
  - SHIFT → LATCH (after the last bit of LED NUM_LEDS-1).
  - LATCH → DONE.
  - DONE → IDLE.
- IDLE: `symbol` = 2'b11. A `start` sampled high moves to FETCH.
- FETCH: `pix_rd` = 1, `pix_addr` = 0.
- LOAD: capture `pix_data` (scaled if configured) into a 24-bit shift register.
- SHIFT:
  - A slot counter counts 0..BIT_CYCLES-1. A bit counter counts 23 down to 0.
  - Slot start: `sym_strobe` = 1 and `symbol` = {1'b0, shreg[23]}. Shift left at slot end.
  - Prefetch: on the first clock of the bit-0 slot, if more LEDs remain, assert `pix_rd` with `pix_addr` = next index.
  - Capture the prefetched word into a holding register on the next clock. Load it into the shift register at the end of the bit-0 slot.
  - Net effect: the next LED's bit 23 slot starts immediately after the previous LED's bit 0 slot.
- LATCH: `symbol` = 2'b11 and `sym_strobe` = 1 on its first clock; lasts RESET_CYCLES clocks.
- DONE: `done` = 1 for one cycle, `busy` still 1; then IDLE.
- `start` outside IDLE is ignored; no queuing.
- `pix_addr` wraps only by returning to 0 at the next frame; it never exceeds NUM_LEDS-1.
- `pix_data` is read exactly once per LED per frame.

## Timing
- Reset (rst_n low at a rising edge): state IDLE, `busy` = 0, `done` = 0, `pix_rd` = 0, `pix_addr` = 0, `sym_strobe` = 0, `symbol` = 2'b11, all counters 0.
- Reset mid-frame aborts immediately; no `done` is issued.
- Startup latency: with `start` accepted at edge k, `pix_rd` is high in cycle k+1 and the first `sym_strobe` is high in cycle k+3.
- Slot boundaries: successive `sym_strobe` pulses are exactly BIT_CYCLES apart across all NUM_LEDS×24 slots. The latch strobe follows the last data strobe by exactly BIT_CYCLES.
- `done` is high exactly RESET_CYCLES clocks after the latch strobe.
- Frame length, accept edge to `done` cycle inclusive: 3 + 24·NUM_LEDS·BIT_CYCLES + RESET_CYCLES clocks.
- `start` held high through DONE: the next frame is accepted at the first IDLE edge (one IDLE cycle minimum between frames).

## Configuration
- `VEO_BRIGHTNESS_EN` defined: each 8-bit channel c of a fetched pixel becomes (c·(brightness+1))>>8. This uses three independent 8×9 products and is applied at capture.
  - `brightness` is sampled when `start` is accepted and held for the frame.
  - brightness = 255 is identity; brightness = 0 yields 0 for every channel.
- Not defined: `pix_data` is passed unmodified, the `brightness` port is ignored, and no multipliers are built.

## Test plan
- Bench parameters: NUM_LEDS=2, BIT_CYCLES=4, RESET_CYCLES=10.
- Reset, then idle 20 cycles → `symbol` = 2'b11, `busy`, `done`, `pix_rd`, `sym_strobe` all 0.
- Memory {0xA50000, 0x00003C}, `start` pulse at edge k → reads at addr 0 (cycle k+1) and addr 1. Symbols are 1010_0101 followed by 16 zeros, then 16 zeros followed by 0011_1100. 48 strobes 4 apart, then latch 2'b11. `done` in cycle k+3+192+10.
- `start` re-asserted during SHIFT and LATCH → ignored; exactly one `done` and 2 `pix_rd` pulses.
- `rst_n` low during LED 1 bit 10 → next cycle IDLE outputs, no `done`. A new `start` then runs a full correct frame.
- `VEO_BRIGHTNESS_EN`, brightness=127, pixel 0xFF8001 → shifted word 0x7F4000. With brightness=255 → unchanged.
- `start` held high continuously → consecutive frames with exactly one IDLE cycle between `done` and the next `pix_rd`-preceding accept.
